vpu_req_arbiter: RTL and testbench

Shares one VPU execution pipeline (controller plus OPGET/EXEC/WB datapath) between REQ_CNT independent requesters. The block sits upstream of the VPU controller's request interface. It picks one requester by round-robin, forwards that requester's registered payload, and holds ownership until the VPU signals completion. It then returns a per-requester response pulse and aborts any job that overruns a cycle budget.

---
 rtl/vpu_req_arbiter.sv | 124 ++++++++++++
 tb/tb_vpu_req_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vpu_req_arbiter.sv
// Round-robin front end for the shared VPU pipeline: grants one requester,
// forwards its latched payload, holds ownership until done or timeout.
module vpu_req_arbiter #(
  parameter int REQ_CNT        = 4,
  parameter int PAYLOAD_W      = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(REQ_CNT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_CNT-1:0]             req_valid_i,
  output logic [REQ_CNT-1:0]             req_ready_o,
  input  logic [REQ_CNT*PAYLOAD_W-1:0]   req_payload_i,
  output logic                           vpu_req_valid_o,
  input  logic                           vpu_req_ready_i,
  output logic [PAYLOAD_W-1:0]           vpu_req_payload_o,
  input  logic                           vpu_done_i,
  output logic [REQ_CNT-1:0]             resp_valid_o,
  output logic                           resp_err_o,
  output logic                           busy_o,
  output logic [ID_W-1:0]                owner_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SUM_W = ID_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]             r_state;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        r_owner;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic [CNT_W-1:0]       r_cnt;
  logic [REQ_CNT-1:0]     r_resp_valid;
  logic                   r_resp_err;

  logic [2*REQ_CNT-1:0]   w_rot;
  logic [SUM_W-1:0]       w_sum;
  logic                   w_found;
  logic [ID_W-1:0]        w_winner;
  logic [PAYLOAD_W-1:0]   w_sel_payload;
  logic                   w_timeout;
  logic                   w_finish;
  logic [ID_W-1:0]        w_owner_next;

  // Rotate the valid vector so bit 0 is the requester at rr_ptr, then take
  // the first set bit and map it back to an absolute index.
  always_comb begin
    w_rot         = {req_valid_i, req_valid_i} >> r_rr_ptr;
    w_found       = 1'b0;
    w_sum         = '0;
    w_winner      = '0;
    w_sel_payload = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found  = 1'b1;
        w_sum    = {1'b0, r_rr_ptr} + SUM_W'(i);
        w_winner = (w_sum >= SUM_W'(REQ_CNT)) ? ID_W'(w_sum - SUM_W'(REQ_CNT))
                                              : ID_W'(w_sum);
      end
    end
    for (int i = 0; i < REQ_CNT; i++) begin
      if (w_winner == ID_W'(i)) begin
        w_sel_payload = req_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_finish     = (r_state == S_BUSY) && (vpu_done_i || w_timeout);
  assign w_owner_next = (r_owner == ID_W'(REQ_CNT - 1)) ? '0 : r_owner + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_payload    <= '0;
      r_cnt        <= '0;
      r_resp_valid <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= '0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_payload <= w_sel_payload;
            r_owner   <= w_winner;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (vpu_req_ready_i) begin
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_finish) begin
            // done has priority over a coincident timeout
            r_resp_valid <= REQ_CNT'(1) << r_owner;
            r_resp_err   <= ~vpu_done_i;
            r_rr_ptr     <= w_owner_next;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o       = ((r_state == S_IDLE) && w_found) ? (REQ_CNT'(1) << w_winner) : '0;
  assign vpu_req_valid_o   = (r_state == S_ISSUE);
  assign vpu_req_payload_o = r_payload;
  assign resp_valid_o      = r_resp_valid;
  assign resp_err_o        = r_resp_err;
  assign busy_o            = (r_state != S_IDLE);
  assign owner_o           = r_owner;

endmodule

// File: tb/tb_vpu_req_arbiter.sv
// Job-level bench for vpu_req_arbiter: directed scenarios plus random jobs
// compared against a round-robin reference model.
module tb_vpu_req_arbiter;

  localparam int N  = 4;
  localparam int PW = 32;
  localparam int TO = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_ready_o;
  logic [N*PW-1:0]   req_payload_i;
  logic              vpu_req_valid_o;
  logic              vpu_req_ready_i;
  logic [PW-1:0]     vpu_req_payload_o;
  logic              vpu_done_i;
  logic [N-1:0]      resp_valid_o;
  logic              resp_err_o;
  logic              busy_o;
  logic [IW-1:0]     owner_o;

  always #5 clk = ~clk;

  vpu_req_arbiter #(.REQ_CNT(N), .PAYLOAD_W(PW), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_payload_i     (req_payload_i),
    .vpu_req_valid_o   (vpu_req_valid_o),
    .vpu_req_ready_i   (vpu_req_ready_i),
    .vpu_req_payload_o (vpu_req_payload_o),
    .vpu_done_i        (vpu_done_i),
    .resp_valid_o      (resp_valid_o),
    .resp_err_o        (resp_err_o),
    .busy_o            (busy_o),
    .owner_o           (owner_o)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          m_rr   = 0;
  logic [PW-1:0] pl [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: first requester at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (((m >> k) & N'(1)) != '0) return k;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    return N'(1) << k;
  endfunction

  task automatic drive_payloads();
    for (int i = 0; i < N; i++) req_payload_i[i*PW +: PW] = pl[i];
  endtask

  task automatic noise();
    req_valid_i = N'($urandom);
    for (int i = 0; i < N; i++) req_payload_i[i*PW +: PW] = $urandom;
  endtask

  // One complete job; entered and left at +2 after a rising edge.
  task automatic do_job(input logic [N-1:0] mask, input int rdy, input int dly, input bit late);
    int w;
    int kend;
    w = pick(mask);
    drive_payloads();
    req_valid_i     = mask;
    vpu_req_ready_i = 1'b0;
    vpu_done_i      = 1'b0;
    #1;
    chk("req_ready_grant", 64'(req_ready_o), 64'(oh(w)));
    chk("busy_in_idle", 64'(busy_o), 64'(0));
    @(posedge clk); #1;
    for (int c = 0; c <= rdy; c++) begin
      noise();
      vpu_req_ready_i = (c == rdy);
      #1;
      chk("vpu_valid_issue", 64'(vpu_req_valid_o), 64'(1));
      chk("vpu_payload", 64'(vpu_req_payload_o), 64'(pl[w]));
      chk("owner", 64'(owner_o), 64'(w));
      chk("no_ready_issue", 64'(req_ready_o), 64'(0));
      if (c == 0) chk("resp_one_cycle", 64'(resp_valid_o), 64'(0));
      @(posedge clk); #1;
    end
    vpu_req_ready_i = 1'b0;
    kend = (dly < TO) ? dly : TO - 1;
    for (int k = 0; k <= kend; k++) begin
      noise();
      vpu_done_i = (k == dly);
      #1;
      chk("busy_state", 64'({busy_o, vpu_req_valid_o, resp_valid_o}), 64'({1'b1, 1'b0, N'(0)}));
      @(posedge clk); #1;
    end
    vpu_done_i  = late;
    req_valid_i = '0;
    #1;
    chk("resp_valid", 64'(resp_valid_o), 64'(oh(w)));
    chk("resp_err", 64'(resp_err_o), 64'(dly >= TO));
    chk("busy_after", 64'(busy_o), 64'(0));
    m_rr = (w + 1) % N;
    if (late) begin
      @(posedge clk); #1;
      vpu_done_i = 1'b0;
      #1;
      chk("late_done_ignored", 64'({resp_valid_o, resp_err_o, busy_o}), 64'(0));
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    req_valid_i     = '0;
    req_payload_i   = '0;
    vpu_req_ready_i = 1'b0;
    vpu_done_i      = 1'b0;
    #1;
    chk("rst_outputs", 64'({busy_o, vpu_req_valid_o, resp_valid_o, resp_err_o, owner_o}), 64'(0));
    chk("rst_payload", 64'(vpu_req_payload_o), 64'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // all four valid: grant order 0,1,2,3,0
    for (int j = 0; j < 5; j++) begin
      int exp_order [5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) pl[i] = $urandom;
      chk("rr_order", 64'(pick(4'b1111)), 64'(exp_order[j]));
      do_job(4'b1111, 0, 2, 1'b0);
    end

    // single requester 2
    for (int i = 0; i < N; i++) pl[i] = $urandom;
    pl[2] = 32'hA5A5_0001;
    do_job(4'b0100, 3, 10, 1'b0);
    chk("rr_after_single", 64'(m_rr), 64'(3));

    // wrap-around: 3 then 0
    do_job(4'b1001, 1, 4, 1'b0);
    do_job(4'b1001, 0, 1, 1'b0);

    // 20-cycle backpressure in issue
    for (int i = 0; i < N; i++) pl[i] = $urandom;
    do_job(4'b0110, 20, 5, 1'b0);

    // timeout with a late done, then done coinciding with the last budget cycle
    do_job(4'b1000, 2, 40, 1'b1);
    do_job(4'b0001, 0, TO - 1, 1'b0);
    do_job(4'b0010, 0, TO, 1'b0);

    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < N; i++) pl[i] = $urandom;
      do_job(N'($urandom_range(1, 15)), $urandom_range(0, 4), $urandom_range(0, 20),
             1'($urandom_range(0, 1)));
    end

    // async reset in the middle of a busy job
    for (int i = 0; i < N; i++) pl[i] = $urandom;
    drive_payloads();
    req_valid_i = 4'b0110;
    @(posedge clk); #1;
    req_valid_i     = '0;
    vpu_req_ready_i = 1'b1;
    @(posedge clk); #1;
    vpu_req_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("busy_before_rst", 64'(busy_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 64'({busy_o, vpu_req_valid_o, resp_valid_o, resp_err_o, owner_o, req_ready_o}), 64'(0));
    chk("async_rst_payload", 64'(vpu_req_payload_o), 64'(0));
    vpu_done_i = 1'b1;
    @(posedge clk); #2;
    vpu_done_i = 1'b0;
    rst_n      = 1'b1;
    m_rr       = 0;
    @(posedge clk); #1;
    chk("no_resp_after_rst", 64'({resp_valid_o, busy_o}), 64'(0));
    for (int i = 0; i < N; i++) pl[i] = $urandom;
    chk("grant_after_rst", 64'(pick(4'b1111)), 64'(0));
    do_job(4'b1111, 1, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
